// File: rtl/nor3_response_checker.sv
// nor3_response_checker: receiving end of the exhaustive A/B/C sweep; compares the two
// NOR outputs of the block under test against ~|ABC after a settle delay and tracks coverage.
`timescale 1ns/1ps
`default_nettype none

module nor3_response_checker #(
   parameter int ERR_W  = 8,
   parameter int SETTLE = 2
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             START,
   input  logic             IN_VALID,
   input  logic [2:0]       ABC,
   input  logic             D,
   input  logic             E,
   output logic             BUSY,
   output logic             DONE,
   output logic             PASS,
   output logic [ERR_W-1:0] ERR_CNT,
   output logic [7:0]       COVER,
   output logic [2:0]       FIRST_ERR_VEC,
   output logic             FIRST_ERR_VALID
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ARM   = 3'd1,
      S_WAIT  = 3'd2,
      S_CHECK = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam bit         HAS_SETTLE  = (SETTLE > 0);
   localparam logic [3:0] SETTLE_LOAD = HAS_SETTLE ? 4'(SETTLE - 1) : 4'd0;

   state_t     state;
   logic [2:0] vec;
   logic [3:0] cnt;

   logic       exp_nor;
   logic       mismatch;
   logic [7:0] cover_next;
   logic       err_full;

   assign exp_nor    = ~|vec;
   assign mismatch   = (D != exp_nor) | (E != exp_nor);
   assign cover_next = COVER | (8'b1 << vec);
   assign err_full   = &ERR_CNT;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state           <= S_IDLE;
         vec             <= 3'd0;
         cnt             <= 4'd0;
         BUSY            <= 1'b0;
         DONE            <= 1'b0;
         PASS            <= 1'b0;
         ERR_CNT         <= '0;
         COVER           <= 8'd0;
         FIRST_ERR_VEC   <= 3'd0;
         FIRST_ERR_VALID <= 1'b0;
      end else if (START) begin
         // Restart from any state; an in-flight vector is abandoned unchecked.
         state           <= S_ARM;
         cnt             <= 4'd0;
         BUSY            <= 1'b1;
         DONE            <= 1'b0;
         PASS            <= 1'b0;
         ERR_CNT         <= '0;
         COVER           <= 8'd0;
         FIRST_ERR_VEC   <= 3'd0;
         FIRST_ERR_VALID <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
            end
            S_ARM: begin
               if (IN_VALID) begin
                  vec <= ABC;
                  if (HAS_SETTLE) begin
                     cnt   <= SETTLE_LOAD;
                     state <= S_WAIT;
                  end else begin
                     state <= S_CHECK;
                  end
               end
            end
            S_WAIT: begin
               if (cnt == 4'd0) state <= S_CHECK;
               else             cnt   <= cnt - 4'd1;
            end
            S_CHECK: begin
               if (mismatch) begin
                  if (!err_full) ERR_CNT <= ERR_CNT + 1'b1;
                  if (!FIRST_ERR_VALID) begin
                     FIRST_ERR_VEC   <= vec;
                     FIRST_ERR_VALID <= 1'b1;
                  end
               end
               COVER <= cover_next;
               if (cover_next == 8'hFF) begin
                  state <= S_DONE;
                  BUSY  <= 1'b0;
                  DONE  <= 1'b1;
                  PASS  <= (ERR_CNT == '0) && !mismatch;
               end else begin
                  state <= S_ARM;
               end
            end
            S_DONE: begin
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_nor3_response_checker.sv
// tb_nor3_response_checker: three builds (default, SETTLE=0, ERR_W=2) share one stimulus
// stream and are checked every cycle against a transaction-level model, plus directed literals.
`timescale 1ns/1ps
`default_nettype none

module tb_nor3_response_checker;

   localparam int NI = 3;

   logic       CLK = 1'b0;
   logic       RST_N = 1'b0;
   logic       START = 1'b0;
   logic       IN_VALID = 1'b0;
   logic [2:0] ABC = 3'd0;
   logic       D = 1'b1;
   logic       E = 1'b1;

   logic [NI-1:0]       busy_o, done_o, pass_o, fval_o;
   logic [NI-1:0][7:0]  cov_o;
   logic [NI-1:0][2:0]  fev_o;
   logic [7:0]          err0, err1;
   logic [1:0]          err2;

   int total = 0;
   int bad   = 0;
   int mode  = 0;
   bit cmp_en = 1'b0;

   always #5 CLK = ~CLK;

   nor3_response_checker #(.ERR_W(8), .SETTLE(2)) dut (
      .CLK(CLK), .RST_N(RST_N), .START(START), .IN_VALID(IN_VALID), .ABC(ABC), .D(D), .E(E),
      .BUSY(busy_o[0]), .DONE(done_o[0]), .PASS(pass_o[0]), .ERR_CNT(err0), .COVER(cov_o[0]),
      .FIRST_ERR_VEC(fev_o[0]), .FIRST_ERR_VALID(fval_o[0]));

   nor3_response_checker #(.ERR_W(8), .SETTLE(0)) dut_s0 (
      .CLK(CLK), .RST_N(RST_N), .START(START), .IN_VALID(IN_VALID), .ABC(ABC), .D(D), .E(E),
      .BUSY(busy_o[1]), .DONE(done_o[1]), .PASS(pass_o[1]), .ERR_CNT(err1), .COVER(cov_o[1]),
      .FIRST_ERR_VEC(fev_o[1]), .FIRST_ERR_VALID(fval_o[1]));

   nor3_response_checker #(.ERR_W(2), .SETTLE(2)) dut_e2 (
      .CLK(CLK), .RST_N(RST_N), .START(START), .IN_VALID(IN_VALID), .ABC(ABC), .D(D), .E(E),
      .BUSY(busy_o[2]), .DONE(done_o[2]), .PASS(pass_o[2]), .ERR_CNT(err2), .COVER(cov_o[2]),
      .FIRST_ERR_VEC(fev_o[2]), .FIRST_ERR_VALID(fval_o[2]));

   function automatic int settle_of(int i);
      return (i == 1) ? 0 : 2;
   endfunction

   function automatic int errmax_of(int i);
      return (i == 2) ? 3 : 255;
   endfunction

   function automatic logic [7:0] err_of(int i);
      if (i == 0) return err0;
      if (i == 1) return err1;
      return {6'd0, err2};
   endfunction

   // Model: a run is "armed" until all 8 values are seen; one pending vector is checked
   // exactly SETTLE+1 edges after it was accepted, and nothing is accepted meanwhile.
   bit         m_run [NI];
   bit         m_done[NI];
   bit         m_fval[NI];
   bit         m_pend[NI];
   int         m_err [NI];
   int         m_due [NI];
   logic [7:0] m_cov [NI];
   logic [2:0] m_fev [NI];
   logic [2:0] m_vec [NI];
   int         t = 0;

   task automatic model_clear(int i);
      m_run[i] = 0; m_done[i] = 0; m_fval[i] = 0; m_pend[i] = 0;
      m_err[i] = 0; m_due[i] = 0; m_cov[i] = 8'd0; m_fev[i] = 3'd0; m_vec[i] = 3'd0;
   endtask

   initial begin : model
      for (int i = 0; i < NI; i++) model_clear(i);
      forever begin
         @(posedge CLK or negedge RST_N);
         if (!RST_N) begin
            for (int i = 0; i < NI; i++) model_clear(i);
         end else begin
            t++;
            for (int i = 0; i < NI; i++) begin
               if (START) begin
                  model_clear(i);
                  m_run[i] = 1;
               end else if (m_run[i] && !m_done[i]) begin
                  if (m_pend[i] && t == m_due[i]) begin
                     logic expv;
                     expv = (m_vec[i] == 3'd0);
                     if (D != expv || E != expv) begin
                        if (m_err[i] < errmax_of(i)) m_err[i]++;
                        if (!m_fval[i]) begin
                           m_fval[i] = 1;
                           m_fev[i]  = m_vec[i];
                        end
                     end
                     m_cov[i][m_vec[i]] = 1'b1;
                     m_pend[i] = 0;
                     if (m_cov[i] == 8'hFF) m_done[i] = 1;
                  end else if (!m_pend[i] && IN_VALID) begin
                     m_pend[i] = 1;
                     m_vec[i]  = ABC;
                     m_due[i]  = t + settle_of(i) + 1;
                  end
               end
            end
         end
      end
   end

   task automatic check(string name, logic [31:0] act, logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, expv, $time);
      end
   endtask

   initial begin : compare
      forever begin
         @(negedge CLK);
         if (cmp_en) begin
            for (int i = 0; i < NI; i++) begin
               check($sformatf("busy[%0d]", i), 32'(busy_o[i]), 32'(m_run[i] && !m_done[i]));
               check($sformatf("done[%0d]", i), 32'(done_o[i]), 32'(m_done[i]));
               check($sformatf("pass[%0d]", i), 32'(pass_o[i]), 32'(m_done[i] && m_err[i] == 0));
               check($sformatf("err[%0d]", i), 32'(err_of(i)), 32'(m_err[i]));
               check($sformatf("cover[%0d]", i), 32'(cov_o[i]), 32'(m_cov[i]));
               check($sformatf("fev[%0d]", i), 32'(fev_o[i]), 32'(m_fev[i]));
               check($sformatf("fval[%0d]", i), 32'(fval_o[i]), 32'(m_fval[i]));
            end
         end
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic set_de();
      logic n;
      n = ~|ABC;
      case (mode)
         1:       begin D = n;    E = (ABC == 3'd0) ? 1'b0 : n; end
         2:       begin D = 1'b1; E = n;  end
         3:       begin D = ~n;   E = ~n; end
         default: begin D = n;    E = n;  end
      endcase
   endtask

   task automatic send(logic [2:0] v);
      ABC = v;
      set_de();
      IN_VALID = 1'b1;
      tick();
      IN_VALID = 1'b0;
      repeat (3) tick();
   endtask

   task automatic pulse_start();
      START = 1'b1;
      tick();
      START = 1'b0;
   endtask

   task automatic sweep();
      for (int v = 0; v < 8; v++) send(3'(v));
   endtask

   initial begin : stim
      #1;
      cmp_en = 1'b1;
      repeat (2) tick();
      check("reset_busy", 32'(busy_o), 32'd0);
      check("reset_cover", 32'(cov_o[0]), 32'd0);
      check("reset_err", 32'(err0), 32'd0);
      RST_N = 1'b1;
      tick();

      // Clean sweep, with DONE timing pinned on both settle builds
      mode = 0;
      pulse_start();
      check("armed_busy", 32'(busy_o[0]), 32'd1);
      for (int v = 0; v < 7; v++) send(3'(v));
      ABC = 3'd7; set_de(); IN_VALID = 1'b1;
      tick();
      IN_VALID = 1'b0;
      check("s0_done_k", 32'(done_o[1]), 32'd0);
      tick();
      check("s0_done_k1", 32'(done_o[1]), 32'd1);
      check("s2_done_k1", 32'(done_o[0]), 32'd0);
      tick();
      check("s2_done_k2", 32'(done_o[0]), 32'd0);
      tick();
      check("s2_done_k3", 32'(done_o[0]), 32'd1);
      check("clean_pass", 32'(pass_o[0]), 32'd1);
      check("clean_cover", 32'(cov_o[0]), 32'hFF);
      check("clean_err", 32'(err0), 32'd0);
      check("clean_fval", 32'(fval_o[0]), 32'd0);
      check("clean_busy", 32'(busy_o[0]), 32'd0);

      // E wrong only for vector 0
      mode = 1;
      pulse_start();
      sweep();
      check("e0_err", 32'(err0), 32'd1);
      check("e0_fev", 32'(fev_o[0]), 32'd0);
      check("e0_fval", 32'(fval_o[0]), 32'd1);
      check("e0_pass", 32'(pass_o[0]), 32'd0);
      check("e0_done", 32'(done_o[0]), 32'd1);

      // D stuck at 1
      mode = 2;
      pulse_start();
      sweep();
      check("d1_err", 32'(err0), 32'd7);
      check("d1_fev", 32'(fev_o[0]), 32'd1);
      check("d1_err_w2", 32'(err2), 32'd3);

      // Both outputs inverted: saturation in the narrow build
      mode = 3;
      pulse_start();
      sweep();
      check("inv_err", 32'(err0), 32'd8);
      check("inv_err_w2", 32'(err2), 32'd3);
      check("inv_pass_w2", 32'(pass_o[2]), 32'd0);
      check("inv_done_w2", 32'(done_o[2]), 32'd1);

      // Repeat vector 5, and an IN_VALID pulse while waiting
      mode = 0;
      pulse_start();
      send(3'd5);
      send(3'd5);
      check("rep_cover", 32'(cov_o[0]), 32'h20);
      ABC = 3'd1; set_de(); IN_VALID = 1'b1;
      tick();
      ABC = 3'd2;
      tick();
      IN_VALID = 1'b0;
      repeat (2) tick();
      check("wait_cover", 32'(cov_o[0]), 32'h22);
      check("wait_cover_s0", 32'(cov_o[1]), 32'h22);
      send(3'd0); send(3'd2); send(3'd3); send(3'd4); send(3'd6);
      check("rep_not_done", 32'(done_o[0]), 32'd0);
      send(3'd7);
      check("rep_done", 32'(done_o[0]), 32'd1);
      check("rep_pass", 32'(pass_o[0]), 32'd1);
      check("rep_err", 32'(err0), 32'd0);

      // Asynchronous reset in the middle of a wait
      pulse_start();
      for (int v = 0; v < 4; v++) send(3'(v));
      ABC = 3'd4; set_de(); IN_VALID = 1'b1;
      tick();
      IN_VALID = 1'b0;
      #2 RST_N = 1'b0;
      #1;
      check("arst_busy", 32'(busy_o), 32'd0);
      check("arst_cover", 32'(cov_o[0]), 32'd0);
      check("arst_err", 32'(err0), 32'd0);
      check("arst_fval", 32'(fval_o[0]), 32'd0);
      tick();
      tick();
      RST_N = 1'b1;
      send(3'd6);
      check("idle_ignores", 32'(cov_o[0]), 32'd0);
      pulse_start();
      sweep();
      check("post_rst_pass", 32'(pass_o[0]), 32'd1);
      pulse_start();
      check("restart_busy", 32'(busy_o[0]), 32'd1);
      check("restart_done", 32'(done_o[0]), 32'd0);
      check("restart_cover", 32'(cov_o[0]), 32'd0);

      // START beats a coincident IN_VALID; SETTLE=0 checks one edge later
      START = 1'b1; IN_VALID = 1'b1; ABC = 3'd3; set_de();
      tick();
      START = 1'b0; IN_VALID = 1'b0;
      repeat (4) tick();
      check("start_wins", 32'(cov_o[0]), 32'd0);
      check("start_wins_s0", 32'(cov_o[1]), 32'd0);
      ABC = 3'd6; set_de(); IN_VALID = 1'b1;
      tick();
      IN_VALID = 1'b0;
      check("s0_cover_k", 32'(cov_o[1]), 32'd0);
      tick();
      check("s0_cover_k1", 32'(cov_o[1]), 32'h40);
      check("s2_cover_k1", 32'(cov_o[0]), 32'd0);
      repeat (3) tick();

      // Randomized traffic, occasional restarts and asynchronous resets
      for (int n = 0; n < 4000; n++) begin
         logic nv;
         START    = ($urandom_range(0, 149) == 0);
         IN_VALID = $urandom_range(0, 1) == 1;
         ABC      = 3'($urandom_range(0, 7));
         nv       = ~|ABC;
         D        = nv ^ ($urandom_range(0, 9) == 0);
         E        = nv ^ ($urandom_range(0, 9) == 0);
         tick();
         if ($urandom_range(0, 799) == 0) begin
            #2 RST_N = 1'b0;
            #4 RST_N = 1'b1;
         end
      end
      START = 1'b0;
      IN_VALID = 1'b0;
      repeat (3) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/nor3_response_checker.md
Name: nor3_response_checker

Overview:
- Synthesizable on-board checker for the three-input NOR gate blocks; it is the receiving end of the exhaustive A/B/C stimulus sweep.
- Accepts each applied input vector plus the DUT's two NOR outputs (D, E), waits a settle interval, and compares both outputs against the expected NOR value.
- Tracks pattern coverage and counts mismatches, then reports DONE/PASS once all 8 patterns have been checked.
- Sits between the stimulus source and board LEDs/status logic.

Parameters:
- ERR_W, 8, width of the mismatch counter; the counter saturates at 2^ERR_W-1.
- SETTLE, 2, clock cycles between accepting a vector and sampling D/E; legal range 0..15.

Ports:
- CLK  input  1  system clock; all state is updated on its rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- START  input  1  one-cycle pulse that clears the results and arms a check run.
- IN_VALID  input  1  ABC holds a newly applied stimulus vector this cycle.
- ABC  input  3  applied vector {A,B,C}; A is the MSB.
- D  input  1  DUT output, first NOR implementation.
- E  input  1  DUT output, second NOR implementation.
- BUSY  output  1  high while the checker is in ARM, WAIT or CHECK.
- DONE  output  1  high in the DONE state.
- PASS  output  1  valid only when DONE=1; high when ERR_CNT==0.
- ERR_CNT  output  ERR_W  number of vectors with a mismatch (saturating).
- COVER  output  8  bit i set once vector value i has been checked.
- FIRST_ERR_VEC  output  3  vector of the first mismatch in the current run.
- FIRST_ERR_VALID  output  1  FIRST_ERR_VEC holds a captured value.

Behaviour:
- Reset (RST_N=0, asynchronous): state=IDLE; all outputs 0, including BUSY, DONE, PASS, ERR_CNT, COVER, FIRST_ERR_VEC and FIRST_ERR_VALID. The internal latch and settle counter are also 0. Reset takes effect in any state, including mid-run.
- IDLE: ignores IN_VALID. START=1 → ARM, and clears ERR_CNT, COVER, FIRST_ERR_* and PASS.
- ARM: IN_VALID=1 at edge k → latch ABC into vec. If SETTLE>0, load the counter with SETTLE-1 and go to WAIT. If SETTLE=0, go directly to CHECK.
- WAIT: decrement the counter each cycle; at 0 → CHECK. IN_VALID is ignored here; the vector is dropped and no status changes.
- CHECK: one cycle.
  - exp = ~(vec[2]|vec[1]|vec[0]).
  - mismatch = (D!=exp)|(E!=exp).
  - On mismatch: ERR_CNT += 1, unless it is already all-ones.
  - On the first mismatch of the run: capture FIRST_ERR_VEC=vec and set FIRST_ERR_VALID=1.
  - COVER[vec] is set whether or not the vector mismatched.
  - If the updated COVER==8'hFF → DONE; otherwise → ARM.
- Timing: for a vector accepted at edge k, the check occurs at edge k+SETTLE+1. The updated ERR_CNT/COVER are visible after that edge. DONE and PASS are visible after the same edge as the final check.
- A repeated vector is rechecked: it counts again for errors and does not change coverage.
- DONE: DONE=1, BUSY=0, PASS=(ERR_CNT==0). Outputs hold until START.
- START in any non-IDLE state (ARM, WAIT, CHECK, DONE): immediate restart. Clear results as in IDLE, go to ARM, and abandon any in-flight vector without checking it.
- START and IN_VALID in the same cycle: START wins; that IN_VALID is not accepted.
- D and E are sampled only in the CHECK cycle. The DUT outputs must be stable by then; the checker does not synchronize them.

Test Plan:
- Reset, then START. Apply vectors 0..7 one at a time (IN_VALID every 4 cycles) with a correct DUT (D=E=~|ABC). Required: COVER=8'hFF, ERR_CNT=0, DONE=1, PASS=1, FIRST_ERR_VALID=0. DONE rises exactly SETTLE+1 edges after the last IN_VALID.
- Same sweep with E forced to 0 for vector 3'b000. Required: ERR_CNT=1, FIRST_ERR_VEC=3'b000, FIRST_ERR_VALID=1, PASS=0. Repeat with D stuck at 1: ERR_CNT=7, FIRST_ERR_VEC is the first nonzero vector applied.
- Apply vector 5 twice, then the remaining vectors. Required: COVER bit 5 set once, DONE only after all 8 are seen. Also pulse IN_VALID during WAIT: that vector is ignored and COVER is unchanged.
- ERR_W=2 build, both outputs inverted for the full sweep. Required: ERR_CNT saturates at 3, PASS=0.
- Drive RST_N low during WAIT after 4 vectors. Required: all outputs become 0 immediately, without waiting for CLK, and the FSM is in IDLE. START plus a full sweep then passes. A START pulse in DONE clears all results and returns BUSY=1.
- SETTLE=0 build: CHECK occurs 1 edge after IN_VALID. START coincident with IN_VALID: the vector is not accepted and COVER=0.
